// File: rtl/dds_frame_pkg.sv
// Shared definitions for the DDS command-frame parser: frame framing bytes,
// parser state encoding and the packed configuration record.
package dds_frame_pkg;

    localparam logic [7:0] FRAME_HEAD  = 8'h55;
    localparam logic [7:0] FRAME_TAIL  = 8'hAA;
    localparam int         PAYLOAD_LEN = 11;
    localparam int         IDX_W       = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CRC     = 2'd2,
        TAIL    = 2'd3
    } frame_st_t;

    // Field order matches payload byte order: byte 0 lands in the MSBs.
    typedef struct packed {
        logic [7:0]  reg_func;
        logic [7:0]  hs_pwm_ch;
        logic [7:0]  hs_ctrl_sta;
        logic [7:0]  duty_num;
        logic [15:0] pulse_dessert;
        logic [7:0]  pulse_num;
        logic [31:0] pat;
    } dds_cfg_t;

    localparam int CFG_W = $bits(dds_cfg_t);

    // Return a copy of the shadow image with payload byte idx replaced by b.
    function automatic logic [CFG_W-1:0] put_byte(
        input logic [CFG_W-1:0] shadow,
        input logic [IDX_W-1:0] idx,
        input logic [7:0]       b
    );
        logic [CFG_W-1:0] img;
        img = shadow;
        for (int i = 0; i < PAYLOAD_LEN; i++) begin
            if (idx == IDX_W'(i)) begin
                img[(PAYLOAD_LEN-1-i)*8 +: 8] = b;
            end
        end
        return img;
    endfunction

endpackage

// File: rtl/frame_gap_timer.sv
// Inter-byte gap timer. Counts idle cycles while enabled and flags the cycle
// in which the count would reach TIMEOUT_CYC. A load in that same cycle wins.
module frame_gap_timer #(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_hit
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_hit = i_en && !i_load && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Idle-cycle counter: cleared by a byte or when disabled, saturates at the limit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_en || i_load) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_W'(TIMEOUT_CYC)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dds_frame_parser.sv
// Command-frame parser: 0x55, 11 payload bytes, XOR CRC, 0xAA. A good frame is
// committed to the configuration outputs in one edge; bad or stalled frames
// are dropped with a one-cycle error pulse and the old configuration is kept.
module dds_frame_parser
    import dds_frame_pkg::*;
#(
    parameter int TIMEOUT_CYC = 20000,
    parameter bit CRC_EN      = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [7:0]  reg_func,
    output logic [7:0]  hs_pwm_ch,
    output logic [7:0]  hs_ctrl_sta,
    output logic [7:0]  duty_num,
    output logic [15:0] pulse_dessert,
    output logic [7:0]  pulse_num,
    output logic [31:0] pat,
    output logic        frame_valid,
    output logic        crc_err,
    output logic        frame_err
);

    frame_st_t        r_state;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_crc_acc;
    logic             r_crc_ok;
    logic [CFG_W-1:0] r_shadow;
    dds_cfg_t         r_cfg;
    logic             r_frame_valid;
    logic             r_crc_err;
    logic             r_frame_err;

    logic             w_timer_en;
    logic             w_timeout;

    // The gap timer only runs while a frame is open.
    assign w_timer_en = (r_state != IDLE);

    frame_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .i_clk  (sys_clk),
        .i_rst  (sys_rst),
        .i_load (rx_done),
        .i_en   (w_timer_en),
        .o_hit  (w_timeout)
    );

    // Frame FSM: shadow capture, CRC accumulation, atomic commit and status pulses.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_crc_acc     <= '0;
            r_crc_ok      <= 1'b0;
            r_shadow      <= '0;
            r_cfg         <= '0;
            r_frame_valid <= 1'b0;
            r_crc_err     <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_crc_err     <= 1'b0;
            r_frame_err   <= 1'b0;
            if (rx_done) begin
                case (r_state)
                    IDLE: begin
                        // Anything but a header is line noise and dropped silently.
                        if (rx_data == FRAME_HEAD) begin
                            r_state   <= PAYLOAD;
                            r_idx     <= '0;
                            r_crc_acc <= '0;
                            r_shadow  <= '0;
                        end
                    end
                    PAYLOAD: begin
                        r_shadow  <= put_byte(r_shadow, r_idx, rx_data);
                        r_crc_acc <= r_crc_acc ^ rx_data;
                        if (r_idx == IDX_W'(PAYLOAD_LEN - 1)) begin
                            r_state <= CRC;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    CRC: begin
                        r_crc_ok <= !CRC_EN || (rx_data == r_crc_acc);
                        r_state  <= TAIL;
                    end
                    TAIL: begin
                        // A wrong tail returns to IDLE without re-reading the byte as a header.
                        if (rx_data != FRAME_TAIL) begin
                            r_frame_err <= 1'b1;
                        end else if (r_crc_ok) begin
                            r_cfg         <= dds_cfg_t'(r_shadow);
                            r_frame_valid <= 1'b1;
                        end else begin
                            r_crc_err <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end else if (w_timeout) begin
                r_frame_err <= 1'b1;
                r_state     <= IDLE;
                r_shadow    <= '0;
            end
        end
    end

    assign reg_func      = r_cfg.reg_func;
    assign hs_pwm_ch     = r_cfg.hs_pwm_ch;
    assign hs_ctrl_sta   = r_cfg.hs_ctrl_sta;
    assign duty_num      = r_cfg.duty_num;
    assign pulse_dessert = r_cfg.pulse_dessert;
    assign pulse_num     = r_cfg.pulse_num;
    assign pat           = r_cfg.pat;
    assign frame_valid   = r_frame_valid;
    assign crc_err       = r_crc_err;
    assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_dds_frame_parser.sv
// Bench for dds_frame_parser: fixed frame table, hand-written timing/reset
// sequences and randomized byte streams, all checked every cycle against a
// frame-level reference model (one instance with CRC checking, one without).
module tb_dds_frame_parser;

    localparam int T = 40;

    localparam logic [111:0] FA         = 112'h55_01_01_01_03_00_44_00_00_00_00_FF_B9_AA;
    localparam logic [111:0] FA_BADCRC  = 112'h55_01_01_01_03_00_44_00_00_00_00_FF_0C_AA;
    localparam logic [111:0] FA_BADTAIL = 112'h55_01_01_01_03_00_44_00_00_00_00_FF_B9_55;
    localparam logic [111:0] FB         = 112'h55_11_22_33_44_55_66_77_88_99_AA_BB_00_AA;
    localparam logic [87:0]  CFG_A      = 88'h01_01_01_03_00_44_00_00_00_00_FF;
    localparam logic [87:0]  CFG_B      = 88'h11_22_33_44_55_66_77_88_99_AA_BB;

    logic        sys_clk;
    logic        sys_rst;
    logic [7:0]  rx_data;
    logic        rx_done;

    logic [7:0]  d0_reg_func, d0_hs_pwm_ch, d0_hs_ctrl_sta, d0_duty_num, d0_pulse_num;
    logic [15:0] d0_pulse_dessert;
    logic [31:0] d0_pat;
    logic        d0_frame_valid, d0_crc_err, d0_frame_err;
    logic [7:0]  d1_reg_func, d1_hs_pwm_ch, d1_hs_ctrl_sta, d1_duty_num, d1_pulse_num;
    logic [15:0] d1_pulse_dessert;
    logic [31:0] d1_pat;
    logic        d1_frame_valid, d1_crc_err, d1_frame_err;

    dds_frame_parser #(.TIMEOUT_CYC(T), .CRC_EN(1'b1)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_data(rx_data), .rx_done(rx_done),
        .reg_func(d0_reg_func), .hs_pwm_ch(d0_hs_pwm_ch), .hs_ctrl_sta(d0_hs_ctrl_sta),
        .duty_num(d0_duty_num), .pulse_dessert(d0_pulse_dessert), .pulse_num(d0_pulse_num),
        .pat(d0_pat), .frame_valid(d0_frame_valid), .crc_err(d0_crc_err), .frame_err(d0_frame_err)
    );

    dds_frame_parser #(.TIMEOUT_CYC(T), .CRC_EN(1'b0)) dut_nocrc (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_data(rx_data), .rx_done(rx_done),
        .reg_func(d1_reg_func), .hs_pwm_ch(d1_hs_pwm_ch), .hs_ctrl_sta(d1_hs_ctrl_sta),
        .duty_num(d1_duty_num), .pulse_dessert(d1_pulse_dessert), .pulse_num(d1_pulse_num),
        .pat(d1_pat), .frame_valid(d1_frame_valid), .crc_err(d1_crc_err), .frame_err(d1_frame_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc_no = 0;

    // Reference model state per instance: open-frame flag, collected bytes, idle gap.
    bit          m_in  [2];
    int          m_n   [2];
    int          m_gap [2];
    logic [7:0]  m_buf [2][13];
    logic [87:0] m_cfg [2];
    logic [2:0]  m_fl  [2];   // {frame_valid, crc_err, frame_err}

    typedef struct {
        logic [135:0] bytes;
        int           n;
        logic [2:0]   fl0;
        logic [2:0]   fl1;
        logic [87:0]  cfg;
    } vec_t;
    vec_t tbl [7];

    logic [7:0] rf [14];
    logic [7:0] x;
    int         rkind, rlen, rrst, hit;

    function automatic logic [90:0] got0();
        return {d0_reg_func, d0_hs_pwm_ch, d0_hs_ctrl_sta, d0_duty_num, d0_pulse_dessert,
                d0_pulse_num, d0_pat, d0_frame_valid, d0_crc_err, d0_frame_err};
    endfunction

    function automatic logic [90:0] got1();
        return {d1_reg_func, d1_hs_pwm_ch, d1_hs_ctrl_sta, d1_duty_num, d1_pulse_dessert,
                d1_pulse_num, d1_pat, d1_frame_valid, d1_crc_err, d1_frame_err};
    endfunction

    task automatic check(input string name, input logic [90:0] act, input logic [90:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc_no, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_in[k] = 1'b0; m_n[k] = 0; m_gap[k] = 0; m_cfg[k] = '0; m_fl[k] = '0;
        end
    endtask

    // One clock edge of the frame-level model.
    task automatic model_step(input int k, input bit crc_en, input bit d, input logic [7:0] b);
        logic [7:0]  acc;
        logic [87:0] p;
        m_fl[k] = 3'b000;
        if (d) begin
            if (!m_in[k]) begin
                if (b == 8'h55) begin
                    m_in[k] = 1'b1; m_n[k] = 0; m_gap[k] = 0;
                end
            end else begin
                m_buf[k][m_n[k]] = b;
                m_n[k]++;
                m_gap[k] = 0;
                if (m_n[k] == 13) begin
                    m_in[k] = 1'b0;
                    acc = 8'h00;
                    p   = '0;
                    for (int i = 0; i < 11; i++) begin
                        acc = acc ^ m_buf[k][i];
                        p   = {p[79:0], m_buf[k][i]};
                    end
                    if (m_buf[k][12] != 8'hAA)                 m_fl[k] = 3'b001;
                    else if (crc_en && (m_buf[k][11] != acc))  m_fl[k] = 3'b010;
                    else begin
                        m_fl[k]  = 3'b100;
                        m_cfg[k] = p;
                    end
                end
            end
        end else if (m_in[k]) begin
            m_gap[k]++;
            if (m_gap[k] == T) begin
                m_fl[k] = 3'b001;
                m_in[k] = 1'b0;
            end
        end
    endtask

    // Drive one cycle (byte or idle), then compare both DUTs with the model.
    task automatic cyc(input bit d, input logic [7:0] b);
        rx_done = d;
        rx_data = d ? b : 8'($urandom);
        @(posedge sys_clk);
        #1;
        rx_done = 1'b0;
        cyc_no++;
        model_step(0, 1'b1, d, b);
        model_step(1, 1'b0, d, b);
        check("crc_on_cycle", got0(), {m_cfg[0], m_fl[0]});
        check("crc_off_cycle", got1(), {m_cfg[1], m_fl[1]});
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        #2;
        model_reset();
        check("reset_zero_crc_on", got0(), 91'b0);
        check("reset_zero_crc_off", got1(), 91'b0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    task automatic send_frame(input logic [111:0] fr, input int gap_after, input int gap_len);
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, fr[(13-i)*8 +: 8]);
            if (i == gap_after) repeat (gap_len) cyc(1'b0, 8'h00);
        end
    endtask

    task automatic random_gap();
        int r;
        int n;
        r = $urandom_range(0, 15);
        n = (r < 10) ? (r % 3) : ((r < 13) ? T - 1 : ((r == 13) ? T : 0));
        repeat (n) cyc(1'b0, 8'h00);
    endtask

    initial begin
        rx_done = 1'b0;
        rx_data = 8'h00;
        sys_rst = 1'b0;
        #1;
        do_reset();
        repeat (2) cyc(1'b0, 8'h00);

        tbl[0] = '{bytes: {24'h0, FA},         n: 14, fl0: 3'b100, fl1: 3'b100, cfg: CFG_A};
        tbl[1] = '{bytes: {24'h0, FA_BADCRC},  n: 14, fl0: 3'b010, fl1: 3'b100, cfg: CFG_A};
        tbl[2] = '{bytes: {24'h0, FA_BADTAIL}, n: 14, fl0: 3'b001, fl1: 3'b001, cfg: CFG_A};
        tbl[3] = '{bytes: {24'h0, FB},         n: 14, fl0: 3'b100, fl1: 3'b100, cfg: CFG_B};
        tbl[4] = '{bytes: {24'h00_AA_13, FA},  n: 17, fl0: 3'b100, fl1: 3'b100, cfg: CFG_A};
        tbl[5] = '{bytes: {24'h0, FB},         n: 14, fl0: 3'b100, fl1: 3'b100, cfg: CFG_B};
        tbl[6] = '{bytes: {24'h0, FA},         n: 14, fl0: 3'b100, fl1: 3'b100, cfg: CFG_A};

        // Table frames, back-to-back with no idle cycles between records.
        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < tbl[r].n; i++) begin
                cyc(1'b1, tbl[r].bytes[(tbl[r].n-1-i)*8 +: 8]);
            end
            check($sformatf("tbl%0d_flags_crc_on", r), 91'({d0_frame_valid, d0_crc_err, d0_frame_err}), 91'(tbl[r].fl0));
            check($sformatf("tbl%0d_flags_crc_off", r), 91'({d1_frame_valid, d1_crc_err, d1_frame_err}), 91'(tbl[r].fl1));
            check($sformatf("tbl%0d_cfg_crc_on", r), 91'(got0() >> 3), 91'(tbl[r].cfg));
            check($sformatf("tbl%0d_cfg_crc_off", r), 91'(got1() >> 3), 91'(tbl[r].cfg));
        end

        // Timeout: frame_err exactly T cycles after the last byte, then recovery.
        cyc(1'b1, 8'h55); cyc(1'b1, 8'h01); cyc(1'b1, 8'h01);
        hit = 0;
        for (int i = 1; i <= T + 4; i++) begin
            cyc(1'b0, 8'h00);
            if (d0_frame_err && hit == 0) hit = i;
        end
        check("timeout_latency", 91'(hit), 91'(T));
        send_frame(FB, 99, 0);
        check("after_timeout_valid", 91'(d0_frame_valid), 91'(1));
        check("after_timeout_cfg", 91'(got0() >> 3), 91'(CFG_B));

        // A byte arriving on the cycle the timer would expire keeps the frame alive.
        send_frame(FA, 4, T - 1);
        check("gap_limit_byte_wins_valid", 91'(d0_frame_valid), 91'(1));
        check("gap_limit_byte_wins_cfg", 91'(got0() >> 3), 91'(CFG_A));

        // Reset after the 6th byte; the frame remainder must be silent.
        for (int i = 0; i < 6; i++) cyc(1'b1, FB[(13-i)*8 +: 8]);
        do_reset();
        for (int i = 6; i < 14; i++) cyc(1'b1, FB[(13-i)*8 +: 8]);
        send_frame(FB, 99, 0);
        check("after_reset_valid", 91'(d0_frame_valid), 91'(1));
        check("after_reset_cfg", 91'(got0() >> 3), 91'(CFG_B));

        // Randomized frames: good, bad CRC, bad tail, truncated, reset mid-frame.
        for (int f = 0; f < 120; f++) begin
            rkind = $urandom_range(0, 9);
            repeat ($urandom_range(0, 2)) begin
                x = 8'($urandom);
                if (x == 8'h55) x = 8'h56;
                cyc(1'b1, x);
            end
            rf[0] = 8'h55;
            x = 8'h00;
            for (int i = 1; i <= 11; i++) begin
                rf[i] = 8'($urandom);
                x = x ^ rf[i];
            end
            rf[12] = x;
            rf[13] = 8'hAA;
            if (rkind == 0) rf[12] = rf[12] ^ 8'($urandom_range(1, 255));
            if (rkind == 1) rf[13] = 8'hAA ^ 8'($urandom_range(1, 255));
            rlen = (rkind == 2) ? $urandom_range(1, 13) : 14;
            rrst = (rkind == 3) ? $urandom_range(1, 12) : 99;
            for (int i = 0; i < rlen; i++) begin
                cyc(1'b1, rf[i]);
                if (i == rrst) do_reset();
                else if (i < rlen - 1) random_gap();
            end
            if (rkind == 2) repeat (T + 2) cyc(1'b0, 8'h00);
            else repeat ($urandom_range(0, 2)) cyc(1'b0, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dds_frame_parser.md
# dds_frame_parser

Byte-level command-frame parser between the UART receiver and the PWM/DDS control registers in `dds_sample_top`. It consumes one received byte per `rx_done` strobe and validates the fixed 14-byte frame: header 0x55, 11 payload bytes, CRC, tail 0xAA. Each good frame is committed atomically to registered configuration outputs. Bad or stalled frames are dropped and flagged, and the previous configuration is kept.

## Interface
- `TIMEOUT_CYC`, default 20000: max `sys_clk` cycles allowed between bytes inside a frame (≈4.6 byte times at 115200 baud, 50 MHz).
- `CRC_EN`, default 1: 1 = check the CRC byte; 0 = ignore the CRC byte value.

Ports:
- `sys_clk`  in  1  system clock.
- `sys_rst`  in  1  reset; asynchronous, active-high.
- `rx_data`  in  8  received byte; valid only while `rx_done`=1.
- `rx_done`  in  1  one-cycle strobe, one per received byte.
- `reg_func`  out  8  payload byte 0.
- `hs_pwm_ch`  out  8  payload byte 1.
- `hs_ctrl_sta`  out  8  payload byte 2.
- `duty_num`  out  8  payload byte 3.
- `pulse_dessert`  out  16  payload bytes 4 (MSB) and 5 (LSB).
- `pulse_num`  out  8  payload byte 6.
- `pat`  out  32  payload bytes 7..10; byte 7 is MSB.
- `frame_valid`  out  1  one-cycle pulse when a frame is committed.
- `crc_err`  out  1  one-cycle pulse on CRC mismatch.
- `frame_err`  out  1  one-cycle pulse on bad tail or inter-byte timeout.

## Operation
- States:
  - IDLE: `rx_done` with 0x55 → PAYLOAD; clear `idx` and `crc_acc`. Any other byte is ignored silently.
  - PAYLOAD: each byte is written to shadow buffer `[idx]`, and `crc_acc ^= byte`. At `idx`=10 → CRC.
  - CRC: store `crc_ok = !CRC_EN || (byte == crc_acc)` → TAIL.
  - TAIL, byte 0xAA with `crc_ok`: copy shadow → outputs, pulse `frame_valid` → IDLE.
  - TAIL, byte 0xAA with !`crc_ok`: pulse `crc_err`; outputs unchanged → IDLE.
  - TAIL, byte ≠ 0xAA: pulse `frame_err`; outputs unchanged → IDLE. The offending byte is not re-examined as a header.
- CRC definition: 8-bit XOR of payload bytes 0..10. Header, CRC and tail bytes are excluded.
- Gap timer:
  - Active in PAYLOAD, CRC and TAIL only.
  - Reloads to 0 on every `rx_done` and increments otherwise.
  - On reaching `TIMEOUT_CYC`: pulse `frame_err` → IDLE; shadow buffer discarded.
- Simultaneous events:
  - `rx_done` in the same cycle the timer reaches its limit: the byte wins and the timer reloads.
  - A 0x55 inside the payload is treated as data.
- At most one of `frame_valid`, `crc_err`, `frame_err` is high in any cycle.

## Timing
- Reset value of every output is 0; the state is IDLE.
- Reset mid-frame discards the partial frame immediately, including the shadow buffer.
- Latency: outputs and `frame_valid` update on the first `sys_clk` edge after the cycle in which the tail byte's `rx_done` is high.
- Outputs are stable between commits; all 88 output bits change on the same edge.
- `crc_err` and `frame_err` assert on that same edge for tail-related errors.
- For timeout, `frame_err` asserts exactly `TIMEOUT_CYC` cycles after the last in-frame `rx_done`.
- Back-to-back frames are allowed. A header byte in the cycle after a commit is accepted, since the state is already IDLE.
- Throughput: one byte per cycle maximum; no backpressure.

## Structure
- Package `dds_frame_pkg`:
  - `FRAME_HEAD` = 8'h55, `FRAME_TAIL` = 8'hAA, `PAYLOAD_LEN` = 11.
  - State enum `frame_st_t` (IDLE, PAYLOAD, CRC, TAIL).
  - Packed struct `dds_cfg_t` holding the output fields.
- One sub-module: `frame_gap_timer`, with load, enable and limit-hit interface, width `$clog2(TIMEOUT_CYC+1)`.

## Test plan
1. **Good frame:** 55 01 01 01 03 00 44 00 00 00 00 FF B9 AA → `frame_valid` pulse. `reg_func`=01, `hs_pwm_ch`=01, `hs_ctrl_sta`=01, `duty_num`=03, `pulse_dessert`=0x0044, `pulse_num`=00, `pat`=0x000000FF.
2. **Bad CRC:** same frame with CRC 0C → `crc_err` pulse, no `frame_valid`, outputs keep the values from test 1. Repeat with `CRC_EN`=0 → `frame_valid`, outputs as in test 1.
3. **Bad tail:** good frame with tail 0x55 → `frame_err`. A following good frame is accepted normally; the bad tail byte is not taken as a header.
4. **Timeout:** send 55 01 01, then idle → `frame_err` exactly `TIMEOUT_CYC` cycles after the last `rx_done`. A subsequent good frame commits.
5. **Noise and back-to-back:** bytes 00 AA 13 before a header are ignored with no flags. Two good frames back-to-back → two `frame_valid` pulses, second frame's values win.
6. **Reset:** assert `sys_rst` after the 6th byte → all outputs 0 immediately. The rest of that frame produces no flags; the next good frame commits.
